// File: rtl/penta_serial_sub.sv
// Digit-serial base-5 subtractor: one (minuend, subtrahend) digit pair per transfer, LSD first,
// with a one-deep registered output stage, a borrow chain, and per-word error tracking.
module penta_serial_sub #(
  parameter int unsigned MAX_DIGITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_a,
  input  logic [2:0] in_b,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_diff,
  output logic       out_last,
  output logic       out_borrow,
  output logic       out_err
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_DIGITS - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic            borrow_q, borrow_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [2:0]      out_diff_q, out_diff_d;
  logic            out_last_q, out_last_d;
  logic            out_borrow_q, out_borrow_d;
  logic            out_err_q, out_err_d;

  logic            accept;
  logic            illegal;
  logic            borrow_in;
  logic [3:0]      sum;
  logic            no_borrow;
  logic [2:0]      legal_diff;
  logic            overflow;
  logic            word_end;
  logic            digit_borrow;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign illegal  = (in_a > 3'd4) || (in_b > 3'd4);

  // A fresh word never inherits a borrow, whatever borrow_q holds.
  assign borrow_in = (state_q == StActive) ? borrow_q : 1'b0;

  // Bias by 5 so the subtraction stays unsigned: sum = a + 5 - b - borrow, range 0..9.
  assign sum          = 4'd5 + {1'b0, in_a} - {1'b0, in_b} - {3'b000, borrow_in};
  assign no_borrow    = (sum >= 4'd5);
  assign legal_diff   = no_borrow ? 3'(sum - 4'd5) : sum[2:0];
  assign digit_borrow = illegal ? borrow_in : !no_borrow;

  assign overflow = (cnt_q == LastCnt) && !in_last;
  assign word_end = in_last || overflow;

  always_comb begin
    state_d      = state_q;
    borrow_d     = borrow_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_diff_d   = out_diff_q;
    out_last_d   = out_last_q;
    out_borrow_d = out_borrow_q;
    out_err_d    = out_err_q;

    if (accept) begin
      out_valid_d  = 1'b1;
      out_diff_d   = illegal ? 3'd0 : legal_diff;
      out_borrow_d = digit_borrow;
      out_last_d   = word_end;
      out_err_d    = err_q || illegal || overflow;
      if (word_end) begin
        state_d  = StIdle;
        borrow_d = 1'b0;
        err_d    = 1'b0;
        cnt_d    = '0;
      end else begin
        state_d  = StActive;
        borrow_d = digit_borrow;
        err_d    = err_q || illegal;
        cnt_d    = cnt_q + CntW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      borrow_q     <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_diff_q   <= 3'd0;
      out_last_q   <= 1'b0;
      out_borrow_q <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      borrow_q     <= borrow_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_diff_q   <= out_diff_d;
      out_last_q   <= out_last_d;
      out_borrow_q <= out_borrow_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_diff   = out_diff_q;
  assign out_last   = out_last_q;
  assign out_borrow = out_borrow_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_penta_serial_sub.sv
// Bench for penta_serial_sub: word-level base-5 model with an expected-digit queue, directed
// literal cases, then randomized traffic with backpressure, illegal digits and resets.
module tb_penta_serial_sub;

  localparam int MAXD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_a = 3'd0;
  logic [2:0] in_b = 3'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_diff;
  logic       out_last;
  logic       out_borrow;
  logic       out_err;

  penta_serial_sub #(.MAX_DIGITS(MAXD)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_last   (out_last),
    .out_borrow (out_borrow),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0] d;
    logic       l;
    logic       b;
    logic       e;
  } dig_t;

  dig_t exp_q[$];
  int   m_borrow = 0;
  int   m_cnt = 0;
  bit   m_err = 0;
  bit   rst_prev = 0;

  // Expected output for one accepted digit pair, straight from the word-level rules.
  task automatic model_push(input int a, input int b, input bit last);
    dig_t r;
    int   t;
    bit   bad, ovf, lst;
    int   bo;
    bad = (a > 4) || (b > 4);
    t   = a - b - m_borrow;
    if (bad) begin
      r.d = 3'd0;
      bo  = m_borrow;
    end else if (t < 0) begin
      r.d = 3'(t + 5);
      bo  = 1;
    end else begin
      r.d = 3'(t);
      bo  = 0;
    end
    m_cnt++;
    ovf = !last && (m_cnt == MAXD);
    lst = last || ovf;
    r.b = bo[0];
    r.l = lst;
    r.e = m_err || bad || ovf;
    if (lst) begin
      m_borrow = 0;
      m_cnt    = 0;
      m_err    = 0;
    end else begin
      m_borrow = bo;
      m_err    = r.e;
    end
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (rst_prev) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_diff", out_diff, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_borrow", out_borrow, 0);
        chk("rst_out_err", out_err, 0);
      end
      exp_q.delete();
      m_borrow = 0;
      m_cnt    = 0;
      m_err    = 0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_without_input", out_valid, 0);
        end else begin
          chk("out_diff", out_diff, exp_q[0].d);
          chk("out_last", out_last, exp_q[0].l);
          chk("out_borrow", out_borrow, exp_q[0].b);
          chk("out_err", out_err, exp_q[0].e);
        end
      end else begin
        chk("missing_output", exp_q.size(), 0);
      end
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) model_push(int'(in_a), int'(in_b), in_last);
    end
    rst_prev = rst;
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("ready_after_rst", in_ready, 1);
  endtask

  // One digit with out_ready high, then literal check of the registered result.
  task automatic send(input int a, input int b, input bit last,
                      input int ed, input int eb, input int el, input int ee);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 3'(a);
    in_b      = 3'(b);
    in_last   = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lit_valid", out_valid, 1);
    chk("lit_diff", out_diff, ed);
    chk("lit_borrow", out_borrow, eb);
    chk("lit_last", out_last, el);
    chk("lit_err", out_err, ee);
  endtask

  initial begin
    do_reset(3);

    send(3, 4, 1, 4, 1, 1, 0);
    send(2, 4, 0, 3, 1, 0, 0);
    send(1, 0, 1, 0, 0, 1, 0);
    send(5, 1, 0, 0, 0, 0, 1);
    send(2, 0, 1, 2, 0, 1, 1);

    for (int i = 0; i < 3; i++) send(1, 0, 0, 1, 0, 0, 0);
    send(1, 0, 0, 1, 0, 1, 1);
    send(1, 0, 0, 1, 0, 0, 0);
    send(1, 0, 1, 1, 0, 1, 0);

    send(0, 1, 0, 4, 1, 0, 0);
    do_reset(2);
    send(4, 0, 1, 4, 0, 1, 0);

    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 3'd3;
    in_b      = 3'd1;
    in_last   = 1'b0;
    @(posedge clk); #1;
    in_a    = 3'd4;
    in_b    = 3'd1;
    in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_diff", out_diff, 2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_diff", out_diff, 3);
    chk("bp_second_last", out_last, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      in_b      = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      in_last   = ($urandom_range(0, 3) == 0);
    end

    @(posedge clk); #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/penta_serial_sub.md
PENTA_SERIAL_SUB -- requirements
Module: penta_serial_sub

Interface
REQ-001 Parameter: MAX_DIGITS, 8, maximum base-5 digits per word (2..16).
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream digit pair valid.
REQ-005 Port: in_ready  output  1  block accepts a digit pair this cycle.
REQ-006 Port: in_a  input  3  minuend digit, LSD first, legal 0..4.
REQ-007 Port: in_b  input  3  subtrahend digit, LSD first, legal 0..4.
REQ-008 Port: in_last  input  1  marks the most significant digit of the word.
REQ-009 Port: out_valid  output  1  difference digit valid.
REQ-010 Port: out_ready  input  1  downstream accepts a digit.
REQ-011 Port: out_diff  output  3  difference digit, 0..4.
REQ-012 Port: out_last  output  1  final digit of the word.
REQ-013 Port: out_borrow  output  1  borrow-out of the current digit; on out_last, 1 means A<B (5^N complement result).
REQ-014 Port: out_err  output  1  word contains an illegal digit or exceeded MAX_DIGITS.

Function
REQ-015 Transfer SHALL occur on an input when in_valid&&in_ready and on an output when out_valid&&out_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready; there is no combinational path from in_* to out_*.
REQ-017 Latency: an accepted digit SHALL appear on out_* on the next cycle.
REQ-018 With out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-019 If out_ready=1 and no input is accepted, out_valid SHALL drop to 0 the next cycle.
REQ-020 Digit arithmetic: t = in_a - in_b - borrow_reg; t<0 -> out_diff=t+5 and borrow-out=1; otherwise out_diff=t and borrow-out=0.
REQ-021 borrow_reg SHALL load borrow-out on each accepted non-last digit and clear to 0 on an accepted last digit.
REQ-022 Control states: IDLE (no word in progress, borrow_reg=0, digit count=0) and ACTIVE (word in progress).
REQ-023 IDLE->ACTIVE on an accepted non-last digit; ACTIVE->IDLE on an accepted last digit; a single-digit word SHALL stay in IDLE.
REQ-024 Digit counter SHALL increment on each accepted digit and clear on return to IDLE.
REQ-025 Illegal digit (in_a>4 or in_b>4): out_diff=0, borrow_reg unchanged, out_err=1 on that digit.
REQ-026 After an illegal digit, out_err SHALL stay 1 on every later digit of the same word, including out_last.
REQ-027 Length overflow: the MAX_DIGITS-th accepted digit without in_last SHALL be treated as last (out_last=1, out_err=1, return to IDLE); the next digit starts a new word.
REQ-028 out_borrow SHALL be valid on every output digit, with meaning as a result flag only on out_last.

Reset
REQ-029 While rst=1: out_valid=0, out_diff=0, out_last=0, out_borrow=0, out_err=0, borrow_reg=0, counter=0, state=IDLE.
REQ-030 Reset SHALL take priority over any handshake in the same cycle; a partially transferred word SHALL be discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-032 Single digit a=3,b=4,last=1 -> out_diff=4, out_borrow=1, out_last=1, out_err=0, one cycle later.
REQ-033 Word A=(2,1), B=(4,0), LSD first (7-4) -> digits (3, borrow 1), then (0, borrow 0, last=1).
REQ-034 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_diff held; after release every digit is delivered once, in order.
REQ-035 Word (a,b)=(5,1),(2,0),last -> first out_diff=0, out_err=1; second out_diff=2, out_err=1, out_last=1.
REQ-036 MAX_DIGITS=4, five (1,0) digits with no in_last -> 4th output has out_last=1 and out_err=1; 5th output begins a new word with out_err=0.
REQ-037 Reset mid-word after a digit with borrow-out=1, then single digit (4,0,last) -> out_diff=4, out_borrow=0.
